// File: rtl/pattern_sequencer.sv
// pattern_sequencer: streams a latched-length table of pixel/color entries to a driver, then triggers a send and waits out an inter-frame gap.
module pattern_sequencer #(
  parameter int GAP_CYCLES = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         run,
  input  logic [6:0]   max_num_loads,
  input  logic [503:0] color_array,
  input  logic [188:0] pixel_array,
  output logic         load_valid,
  input  logic         load_ready,
  output logic [2:0]   load_pixel,
  output logic [7:0]   load_color,
  output logic         send_go,
  input  logic         send_done,
  output logic         busy,
  output logic [7:0]   frame_count
);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
  localparam logic [15:0] GAP_LD = 16'(GAP_CYCLES);
  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d, n_q, n_d, n_clamp;
  logic [15:0] gap_q, gap_d;
  logic        load_valid_q, load_valid_d, send_go_q, send_go_d, busy_q, busy_d, fetch;
  logic [2:0]  load_pixel_q, load_pixel_d;
  logic [7:0]  load_color_q, load_color_d, frame_count_q, frame_count_d;
  assign n_clamp = max_num_loads == 7'd0 ? 6'd1 : max_num_loads > 7'd63 ? 6'd63 : max_num_loads[5:0];
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    n_d           = n_q;
    gap_d         = gap_q;
    load_valid_d  = load_valid_q;
    send_go_d     = 1'b0;
    frame_count_d = frame_count_q;
    fetch         = 1'b0;
    case (state_q)
      IDLE: if (run) begin
        state_d      = LOAD;
        idx_d        = 6'd0;
        n_d          = n_clamp;
        load_valid_d = 1'b1;
        fetch        = 1'b1;
      end
      LOAD: if (load_valid_q && load_ready) begin
        if (idx_q == n_q - 6'd1) begin
          state_d      = SEND;
          load_valid_d = 1'b0;
          send_go_d    = 1'b1;
        end else begin
          idx_d = idx_q + 6'd1;
          fetch = 1'b1;
        end
      end
      SEND: if (send_done) begin
        state_d       = GAP;
        frame_count_d = frame_count_q + 8'd1;
        gap_d         = GAP_LD;
      end
      default: begin
        gap_d = gap_q - 16'd1;
        if (gap_q <= 16'd1) begin
          gap_d        = 16'd0;
          state_d      = run ? LOAD : IDLE;
          idx_d        = 6'd0;
          n_d          = run ? n_clamp : n_q;
          load_valid_d = run;
          fetch        = run;
        end
      end
    endcase
    load_pixel_d = fetch ? pixel_array[3*idx_d +: 3] : load_pixel_q;
    load_color_d = fetch ? color_array[8*idx_d +: 8] : load_color_q;
    busy_d       = state_d != IDLE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      n_q           <= '0;
      gap_q         <= '0;
      load_valid_q  <= 1'b0;
      load_pixel_q  <= '0;
      load_color_q  <= '0;
      send_go_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      n_q           <= n_d;
      gap_q         <= gap_d;
      load_valid_q  <= load_valid_d;
      load_pixel_q  <= load_pixel_d;
      load_color_q  <= load_color_d;
      send_go_q     <= send_go_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
    end
  end
  assign load_valid  = load_valid_q;
  assign load_pixel  = load_pixel_q;
  assign load_color  = load_color_q;
  assign send_go     = send_go_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: randomized frame scenarios checked against a table-driven model of the expected entry stream.
module tb_pattern_sequencer;
  localparam int GAP = 5;
  logic         clk = 1'b0;
  logic         reset, run, load_ready, send_done;
  logic [6:0]   max_num_loads;
  logic [503:0] color_array;
  logic [188:0] pixel_array;
  logic         load_valid, send_go, busy;
  logic [2:0]   load_pixel;
  logic [7:0]   load_color, frame_count;
  logic [7:0]   cmem[63];
  logic [2:0]   pmem[63];
  logic [7:0]   exp_fc;
  int total = 0;
  int bad = 0;
  pattern_sequencer #(.GAP_CYCLES(GAP)) dut (
    .clock(clk), .reset(reset), .run(run), .max_num_loads(max_num_loads),
    .color_array(color_array), .pixel_array(pixel_array),
    .load_valid(load_valid), .load_ready(load_ready), .load_pixel(load_pixel),
    .load_color(load_color), .send_go(send_go), .send_done(send_done),
    .busy(busy), .frame_count(frame_count)
  );
  for (genvar g = 0; g < 63; g++) begin : g_pack
    assign color_array[g*8 +: 8] = cmem[g];
    assign pixel_array[g*3 +: 3] = pmem[g];
  end
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_frame(input int m, input int stall_idx, input int stall_len, input int drop_idx);
    int n, d;
    n = m == 0 ? 1 : (m > 63 ? 63 : m);
    foreach (cmem[k]) begin
      cmem[k] = 8'($urandom);
      pmem[k] = 3'($urandom);
    end
    max_num_loads = 7'(m);
    load_ready = 1'b1;
    tick;
    max_num_loads = 7'($urandom);
    total++;
    if ({load_valid, busy} !== 2'b11) begin
      bad++;
      $display("FAIL start: valid/busy=%b want 11", {load_valid, busy});
    end
    for (int i = 0; i < n; i++) begin
      if (i == drop_idx) run = 1'b0;
      total++;
      if ({load_valid, send_go, load_pixel, load_color} !== {2'b10, pmem[i], cmem[i]}) begin
        bad++;
        $display("FAIL entry%0d of %0d: got %h want %h", i, n, {load_valid, send_go, load_pixel, load_color}, {2'b10, pmem[i], cmem[i]});
      end
      if (i == stall_idx) begin
        load_ready = 1'b0;
        repeat (stall_len) begin
          tick;
          total++;
          if ({load_valid, send_go, load_pixel, load_color} !== {2'b10, pmem[i], cmem[i]}) begin
            bad++;
            $display("FAIL hold%0d: got %h want %h", i, {load_valid, send_go, load_pixel, load_color}, {2'b10, pmem[i], cmem[i]});
          end
        end
        load_ready = 1'b1;
      end
      tick;
    end
    load_ready = 1'($urandom);
    total++;
    if ({load_valid, send_go, busy} !== 3'b011) begin
      bad++;
      $display("FAIL send_go: valid/go/busy=%b want 011", {load_valid, send_go, busy});
    end
    d = $urandom_range(0, 3);
    for (int w = 0; w <= d; w++) begin
      tick;
      total++;
      if ({load_valid, send_go, busy, frame_count} !== {3'b001, exp_fc}) begin
        bad++;
        $display("FAIL send_wait: got %h want %h", {load_valid, send_go, busy, frame_count}, {3'b001, exp_fc});
      end
    end
    send_done = 1'b1;
    tick;
    send_done = 1'b0;
    exp_fc = exp_fc + 8'd1;
    total++;
    if ({load_valid, send_go, busy, frame_count} !== {3'b001, exp_fc}) begin
      bad++;
      $display("FAIL frame_count: got %h want %h", {load_valid, send_go, busy, frame_count}, {3'b001, exp_fc});
    end
    for (int g = 1; g < GAP; g++) begin
      send_done = (g == 2);
      tick;
      total++;
      if ({load_valid, send_go, busy, frame_count} !== {3'b001, exp_fc}) begin
        bad++;
        $display("FAIL gap%0d: got %h want %h", g, {load_valid, send_go, busy, frame_count}, {3'b001, exp_fc});
      end
    end
    send_done = 1'b0;
    load_ready = 1'b1;
  endtask
  task automatic expect_idle(input string tag);
    total++;
    if ({load_valid, send_go, busy, frame_count} !== {3'b000, exp_fc}) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, {load_valid, send_go, busy, frame_count}, {3'b000, exp_fc});
    end
  endtask
  task automatic test_reset;
    reset = 1'b0;
    repeat (3) tick;
    total++;
    if ({load_valid, load_pixel, load_color, send_go, busy, frame_count} !== '0) begin
      bad++;
      $display("FAIL reset: got %h want 0", {load_valid, load_pixel, load_color, send_go, busy, frame_count});
    end
    reset = 1'b1;
    exp_fc = 8'd0;
    tick;
  endtask
  task automatic test_basic;
    run = 1'b1;
    run_frame(3, -1, 0, -1);
    run = 1'b0;
    tick;
    expect_idle("basic_idle");
  endtask
  task automatic test_stall;
    run = 1'b1;
    run_frame(4, 1, 5, -1);
    run = 1'b0;
    tick;
    expect_idle("stall_idle");
  endtask
  task automatic test_clamp;
    run = 1'b1;
    run_frame(0, -1, 0, -1);
    run_frame(100, 62, 2, -1);
    run = 1'b0;
    tick;
    expect_idle("clamp_idle");
  endtask
  task automatic test_run_drop;
    run = 1'b1;
    run_frame($urandom_range(4, 10), -1, 0, 1);
    tick;
    expect_idle("drop_idle");
    send_done = 1'b1;
    repeat (3) tick;
    send_done = 1'b0;
    expect_idle("spurious_idle");
  endtask
  task automatic test_random;
    int m;
    run = 1'b1;
    repeat (6) begin
      m = $urandom_range(0, 70);
      run_frame(m, $urandom_range(0, 8), $urandom_range(1, 4), -1);
    end
    run = 1'b0;
    tick;
    expect_idle("random_idle");
  endtask
  task automatic test_wrap;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    exp_fc = 8'd0;
    tick;
    run = 1'b1;
    repeat (256) run_frame($urandom_range(1, 2), -1, 0, -1);
    run = 1'b0;
    tick;
    total++;
    if (frame_count !== 8'd0) begin
      bad++;
      $display("FAIL wrap: frame_count=%0d want 0", frame_count);
    end
  endtask
  task automatic test_reset_mid;
    max_num_loads = 7'd10;
    load_ready = 1'b0;
    run = 1'b1;
    tick;
    tick;
    run = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++;
    if ({load_valid, load_pixel, load_color, send_go, busy, frame_count} !== '0) begin
      bad++;
      $display("FAIL reset_mid: got %h want 0", {load_valid, load_pixel, load_color, send_go, busy, frame_count});
    end
    tick;
    reset = 1'b1;
    load_ready = 1'b1;
    exp_fc = 8'd0;
    for (int c = 0; c < 12; c++) begin
      tick;
      total++;
      if ({load_valid, send_go, busy} !== 3'b000) begin
        bad++;
        $display("FAIL post_reset%0d: valid/go/busy=%b want 000", c, {load_valid, send_go, busy});
      end
    end
  endtask
  initial begin
    reset = 1'b0;
    run = 1'b0;
    load_ready = 1'b0;
    send_done = 1'b0;
    max_num_loads = 7'd0;
    foreach (cmem[k]) begin
      cmem[k] = 8'd0;
      pmem[k] = 3'd0;
    end
    exp_fc = 8'd0;
    test_reset;
    test_basic;
    test_stall;
    test_clamp;
    test_run_drop;
    test_random;
    test_wrap;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16, giving idle cycles between frames (legal 1..65535).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port run  input  1  level; 1 = keep sequencing frames.
REQ-005 SHALL have port max_num_loads  input  7  entries per frame.
REQ-006 SHALL have port color_array  input  63x8  color value per entry.
REQ-007 SHALL have port pixel_array  input  63x3  pixel code per entry.
REQ-008 SHALL have port load_valid  output  1  entry offered to the pixel driver.
REQ-009 SHALL have port load_ready  input  1  driver accepts the entry.
REQ-010 SHALL have port load_pixel  output  3  pixel code of the offered entry.
REQ-011 SHALL have port load_color  output  8  color value of the offered entry.
REQ-012 SHALL have port send_go  output  1  one-cycle pulse: driver transmits the frame.
REQ-013 SHALL have port send_done  input  1  driver finished transmitting.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port frame_count  output  8  completed frames, modulo 256.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, SEND, GAP; all outputs registered.
REQ-017 SHALL, in IDLE with run=1, go to LOAD, set idx=0, and latch N = max_num_loads.
REQ-018 SHALL clamp the latched N: 0 is treated as 1, and values above 63 are treated as 63.
REQ-019 SHALL map entry idx to array slice [idx], with slice 0 being the least-significant slice.
REQ-020 SHALL assert load_valid in the first LOAD cycle, with load_pixel and load_color taken from entry idx.
REQ-021 SHALL count a transfer only when load_valid=1 and load_ready=1 in the same cycle.
REQ-022 SHALL hold load_valid, load_pixel and load_color stable while load_valid=1 and load_ready=0.
REQ-023 SHALL, on a transfer with idx<N-1, increment idx and present the next entry on the following cycle with load_valid kept high.
REQ-024 SHALL, on a transfer with idx=N-1, clear load_valid next cycle, pulse send_go for exactly one cycle, and enter SEND.
REQ-025 SHALL, in SEND, wait for send_done=1, then increment frame_count (wrapping 255 to 0), load the gap counter with GAP_CYCLES, and enter GAP.
REQ-026 SHALL, in GAP, decrement the counter each cycle; when it reaches 0 it goes to LOAD if run=1 (idx=0, re-latch N), else to IDLE.
REQ-027 SHALL ignore send_done in any state other than SEND.
REQ-028 SHALL ignore load_ready whenever load_valid=0.
REQ-029 SHALL, on run deasserting mid-frame, finish the current frame and its gap, then go to IDLE.
REQ-030 SHALL use the max_num_loads value latched at frame start for the whole frame, ignoring later changes.
REQ-031 SHALL sample color_array and pixel_array combinationally at idx only when loading the output registers.
REQ-032 SHALL give a latency of 1 cycle from run=1 sampled in IDLE to load_valid=1.
REQ-033 SHALL allow load_ready held at 1 to give one transfer per cycle.

Reset
REQ-034 SHALL, on reset low and asynchronously, go to IDLE and clear idx, N, the gap counter, load_valid, load_pixel, load_color, send_go and frame_count.
REQ-035 SHALL hold busy at 0 during reset.
REQ-036 SHALL leave a frame in progress when reset is asserted abandoned; after release, nothing is emitted until run=1 is sampled in IDLE.

Verification
REQ-037 SHALL verify: run=1, max_num_loads=3, load_ready=1 -> entries 0,1,2 on three consecutive cycles, send_go on the next cycle, one frame_count increment after send_done.
REQ-038 SHALL verify: load_ready low for 5 cycles on entry 1 -> outputs held unchanged, no idx skip, entry 2 follows the accepting cycle.
REQ-039 SHALL verify: max_num_loads=0, then 100 -> exactly 1 entry per frame, then exactly 63 entries, the last being slice 62.
REQ-040 SHALL verify: run dropped during LOAD -> frame completes, GAP_CYCLES idle cycles follow, then IDLE with busy=0; a spurious send_done in GAP or IDLE has no effect.
REQ-041 SHALL verify: 256 frames -> frame_count wraps to 0; reset asserted mid-LOAD -> all outputs zero immediately, no send_go after release while run=0.
